// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   // Default number of denied debug cycles tolerated before debug is forced through.
   localparam int unsigned MAX_WAIT_DEFAULT = 4;

   // Width of the saturating conflict counter.
   localparam int unsigned CONFLICT_W = 16;

   // Owner of the memory port in the previous cycle; selects where read data returns.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CORE = 2'd1,
      S_DBG  = 2'd2
   } arb_state_e;

   // Bits needed to hold 0..max_wait; never narrower than one bit.
   function automatic int unsigned wait_width(input int unsigned max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear, used to track debug starvation.
module arb_wait_counter #(
   parameter int unsigned MAX = 4,
   parameter int unsigned W   = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   // Count up while requested, hold at MAX, clear takes priority over increment.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt < W'(MAX))) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter in front of a single combinational-read data memory.
// Core has priority; debug is forced through after MAX_WAIT consecutive denied cycles.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset,
   // core port
   input  logic                  core_req,
   input  logic                  core_we,
   input  logic [AW-1:0]         core_addr,
   input  logic [DW-1:0]         core_wdata,
   output logic                  core_gnt,
   output logic                  core_rvalid,
   output logic [DW-1:0]         core_rdata,
   // debug / loader port
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [AW-1:0]         dbg_addr,
   input  logic [DW-1:0]         dbg_wdata,
   output logic                  dbg_gnt,
   output logic                  dbg_rvalid,
   output logic [DW-1:0]         dbg_rdata,
   // memory side
   output logic                  mem_we,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_wdata,
   input  logic [DW-1:0]         mem_rdata,
   // statistics
   output logic [CONFLICT_W-1:0] conflict_cnt
);

   localparam int unsigned WAIT_W = wait_width(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt;
   logic              force_dbg;
   logic              both_req;
   logic              wait_inc;
   logic              wait_clr;
   arb_state_e        state;
   logic              rd_q;

   assign both_req  = core_req & dbg_req;
   assign force_dbg = (wait_cnt == WAIT_W'(MAX_WAIT));

   // Grant decision: core wins unless debug has waited long enough; nothing during reset.
   always_comb begin
      core_gnt = 1'b0;
      dbg_gnt  = 1'b0;
      if (reset) begin
         if (dbg_req && (!core_req || force_dbg)) begin
            dbg_gnt = 1'b1;
         end else if (core_req) begin
            core_gnt = 1'b1;
         end
      end
   end

   // Debug starvation tracking: count denied debug cycles, clear on grant or idle.
   assign wait_inc = dbg_req & ~dbg_gnt;
   assign wait_clr = ~dbg_req | dbg_gnt;

   arb_wait_counter #(
      .MAX (MAX_WAIT),
      .W   (WAIT_W)
   ) u_wait_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (wait_inc),
      .clr   (wait_clr),
      .cnt   (wait_cnt)
   );

   // Route the granted port onto the memory bus; the bus is all-zero when idle.
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (core_gnt) begin
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
      end else if (dbg_gnt) begin
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
      end
   end

   // Owner FSM: remember who was granted and whether it was a read; capture read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         rd_q       <= 1'b0;
         core_rdata <= '0;
         dbg_rdata  <= '0;
      end else begin
         if (core_gnt) begin
            state <= S_CORE;
            rd_q  <= ~core_we;
            if (!core_we) begin
               core_rdata <= mem_rdata;
            end
         end else if (dbg_gnt) begin
            state <= S_DBG;
            rd_q  <= ~dbg_we;
            if (!dbg_we) begin
               dbg_rdata <= mem_rdata;
            end
         end else begin
            state <= S_IDLE;
            rd_q  <= 1'b0;
         end
      end
   end

   // Read response goes to whichever port owned the bus in the previous cycle.
   assign core_rvalid = (state == S_CORE) & rd_q;
   assign dbg_rvalid  = (state == S_DBG)  & rd_q;

   // Saturating count of cycles in which both ports requested.
   always_ff @(posedge clk) begin
      if (!reset) begin
         conflict_cnt <= '0;
      end else if (both_req && (conflict_cnt != {CONFLICT_W{1'b1}})) begin
         conflict_cnt <= conflict_cnt + CONFLICT_W'(1);
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_req, core_we, core_gnt, core_rvalid;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_wdata, dbg_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [15:0]   conflict_cnt;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
      .clk          (clk),
      .reset        (reset),
      .core_req     (core_req),
      .core_we      (core_we),
      .core_addr    (core_addr),
      .core_wdata   (core_wdata),
      .core_gnt     (core_gnt),
      .core_rvalid  (core_rvalid),
      .core_rdata   (core_rdata),
      .dbg_req      (dbg_req),
      .dbg_we       (dbg_we),
      .dbg_addr     (dbg_addr),
      .dbg_wdata    (dbg_wdata),
      .dbg_gnt      (dbg_gnt),
      .dbg_rvalid   (dbg_rvalid),
      .dbg_rdata    (dbg_rdata),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .conflict_cnt (conflict_cnt)
   );

   // 16-word data memory driven by the DUT's memory bus.
   logic [31:0] bmem [16];
   assign mem_rdata = bmem[mem_addr[5:2]];
   always @(posedge clk) if (mem_we) bmem[mem_addr[5:2]] <= mem_wdata;

   function automatic logic [31:0] init_word(input int i);
      if (i == 0) return 32'h1234_5678;
      if (i == 2) return 32'hCAFE_F00D;
      return 32'h5000_0000 + 32'(i) * 32'h0101_0101;
   endfunction

   // Behavioural model state.
   int          m_wait = 0;
   int          m_conf = 0;
   bit          m_crv = 1'b0, m_drv = 1'b0;
   logic [31:0] m_crd = '0, m_drd = '0;
   logic [31:0] m_mem [16];
   bit          m_cg = 1'b0, m_dg = 1'b0;
   bit          chk_en = 1'b0;
   int          n_cmp = 0, n_bad = 0;

   bit          eg_c, eg_d, e_we;
   logic [31:0] e_addr, e_wd;
   int          idx;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Every cycle: predict outputs from the rules, compare, then advance the model.
   always @(negedge clk) begin
      if (chk_en) begin
         eg_c = 1'b0;
         eg_d = 1'b0;
         if (reset) begin
            if (core_req && dbg_req) begin
               if (m_wait >= MAX_WAIT) eg_d = 1'b1;
               else                    eg_c = 1'b1;
            end else if (core_req) begin
               eg_c = 1'b1;
            end else if (dbg_req) begin
               eg_d = 1'b1;
            end
         end
         e_we = 1'b0; e_addr = '0; e_wd = '0;
         if (eg_c) begin
            e_we = core_we; e_addr = core_addr; e_wd = core_wdata;
         end else if (eg_d) begin
            e_we = dbg_we;  e_addr = dbg_addr;  e_wd = dbg_wdata;
         end

         check("core_gnt",     32'(core_gnt),     32'(eg_c));
         check("dbg_gnt",      32'(dbg_gnt),      32'(eg_d));
         check("mem_we",       32'(mem_we),       32'(e_we));
         check("mem_addr",     mem_addr,          e_addr);
         check("mem_wdata",    mem_wdata,         e_wd);
         check("core_rvalid",  32'(core_rvalid),  32'(m_crv));
         check("dbg_rvalid",   32'(dbg_rvalid),   32'(m_drv));
         check("core_rdata",   core_rdata,        m_crd);
         check("dbg_rdata",    dbg_rdata,         m_drd);
         check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));

         m_cg = eg_c;
         m_dg = eg_d;
         if (!reset) begin
            m_wait = 0; m_conf = 0;
            m_crv = 1'b0; m_drv = 1'b0;
            m_crd = '0; m_drd = '0;
         end else begin
            idx   = int'(e_addr[5:2]);
            m_crv = eg_c && !e_we;
            m_drv = eg_d && !e_we;
            if (m_crv) m_crd = m_mem[idx];
            if (m_drv) m_drd = m_mem[idx];
            if (e_we)  m_mem[idx] = e_wd;
            if (dbg_req && !eg_d) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
            else                  m_wait = 0;
            if (core_req && dbg_req && m_conf < 65535) m_conf++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req = 1'b0; core_we = 1'b0;
      dbg_req  = 1'b0; dbg_we  = 1'b0;
   endtask

   task automatic core_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd;
   endtask

   task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd;
   endtask

   function automatic logic [31:0] rand_addr();
      return 32'h0040_0000 + 32'($urandom_range(0, 15)) * 32'd4;
   endfunction

   bit c_pend, d_pend;

   initial begin
      for (int i = 0; i < 16; i++) begin
         bmem[i]  = init_word(i);
         m_mem[i] = init_word(i);
      end
      reset = 1'b0;
      idle();
      core_addr = '0; core_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
      core_req = 1'b1; dbg_req = 1'b1;

      // reset holds grants and counters low even with both ports requesting
      step();
      chk_en = 1'b1;
      #2;
      check("rst_core_gnt", 32'(core_gnt), 32'd0);
      check("rst_dbg_gnt",  32'(dbg_gnt),  32'd0);
      check("rst_mem_we",   32'(mem_we),   32'd0);
      check("rst_conflict", 32'(conflict_cnt), 32'd0);
      step(); step();
      reset = 1'b1;
      idle();

      // core-only read
      step();
      core_drive(1'b0, 32'h0040_0000, 32'h0);
      #2;
      check("cr_gnt",  32'(core_gnt), 32'd1);
      check("cr_addr", mem_addr, 32'h0040_0000);
      step();
      idle();
      #2;
      check("cr_rvalid",  32'(core_rvalid), 32'd1);
      check("cr_rdata",   core_rdata, 32'h1234_5678);
      check("cr_dbg_rv",  32'(dbg_rvalid), 32'd0);

      // debug write
      step();
      dbg_drive(1'b1, 32'h0040_0004, 32'hDEAD_BEEF);
      #2;
      check("dw_gnt",   32'(dbg_gnt), 32'd1);
      check("dw_we",    32'(mem_we), 32'd1);
      check("dw_addr",  mem_addr, 32'h0040_0004);
      check("dw_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      idle();
      #2;
      check("dw_core_rv", 32'(core_rvalid), 32'd0);
      check("dw_dbg_rv",  32'(dbg_rvalid), 32'd0);

      // alternating reads, back to back
      step();
      core_drive(1'b0, 32'h0040_0000, 32'h0);
      step();
      idle();
      dbg_drive(1'b0, 32'h0040_0008, 32'h0);
      #2;
      check("alt_core_rv", 32'(core_rvalid), 32'd1);
      check("alt_core_rd", core_rdata, 32'h1234_5678);
      step();
      idle();
      #2;
      check("alt_dbg_rv",  32'(dbg_rvalid), 32'd1);
      check("alt_dbg_rd",  dbg_rdata, 32'hCAFE_F00D);
      check("alt_core_rv0", 32'(core_rvalid), 32'd0);

      // contention: core x4, debug once, then core again
      step();
      core_drive(1'b0, 32'h0040_0010, 32'h0);
      dbg_drive(1'b0, 32'h0040_0014, 32'h0);
      for (int i = 0; i < 6; i++) begin
         #2;
         check("cont_dbg_gnt",  32'(dbg_gnt),  (i == 4) ? 32'd1 : 32'd0);
         check("cont_core_gnt", 32'(core_gnt), (i == 4) ? 32'd0 : 32'd1);
         step();
      end
      idle();
      #2;
      check("cont_conflict", 32'(conflict_cnt), 32'd6);

      // reset asserted in the grant cycle of a core read
      step();
      core_drive(1'b0, 32'h0040_0000, 32'h0);
      reset = 1'b0;
      #2;
      check("rmr_gnt", 32'(core_gnt), 32'd0);
      step();
      reset = 1'b1;
      idle();
      #2;
      check("rmr_rvalid",   32'(core_rvalid), 32'd0);
      check("rmr_conflict", 32'(conflict_cnt), 32'd0);
      step();
      #2;
      check("rmr_rvalid2",  32'(core_rvalid), 32'd0);

      // randomized traffic obeying the hold-until-granted rule
      c_pend = 1'b0;
      d_pend = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         step();
         if (m_cg) c_pend = 1'b0;
         if (m_dg) d_pend = 1'b0;
         if (!c_pend && ($urandom_range(0, 99) < 60)) begin
            c_pend = 1'b1;
            core_we = ($urandom_range(0, 2) == 0);
            core_addr = rand_addr();
            core_wdata = $urandom;
         end
         if (!d_pend && ($urandom_range(0, 99) < 50)) begin
            d_pend = 1'b1;
            dbg_we = ($urandom_range(0, 2) == 0);
            dbg_addr = rand_addr();
            dbg_wdata = $urandom;
         end
         core_req = c_pend;
         dbg_req  = d_pend;
         reset    = ($urandom_range(0, 249) != 0);
      end

      // conflict counter saturation
      step();
      reset = 1'b0;
      idle();
      step();
      reset = 1'b1;
      core_drive(1'b0, 32'h0040_0018, 32'h0);
      dbg_drive(1'b0, 32'h0040_001C, 32'h0);
      repeat (70000) step();
      #2;
      check("sat_conflict", 32'(conflict_cnt), 32'h0000_FFFF);
      step();
      #2;
      check("sat_stable", 32'(conflict_cnt), 32'h0000_FFFF);
      idle();
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
